apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command interface into APB3/APB4 transfers to a single APB slave.
- Returns each transfer's result on a buffered response interface.
- Sits directly upstream of the APB slave and its protocol checker; drives PADDR/PWRITE/PWDATA/PSTRB/PPROT/PSELx/PENABLE.
- Enforces a PREADY timeout so a hung slave cannot stall the system.

Parameters:
DATA_WIDTH, 32, APB data width in bits; must be a multiple of 8
ADDR_WIDTH, 32, APB address width in bits
TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous active-high reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when high with req_valid
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  transfer address
req_wdata  input  DATA_WIDTH  write data
req_strb  input  DATA_WIDTH/8  write byte strobes
req_prot  input  3  protection attributes
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_slverr  output  1  PSLVERR from slave, or 1 on timeout
rsp_timeout  output  1  transfer aborted by timeout
PADDR  output  ADDR_WIDTH  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PSTRB  output  DATA_WIDTH/8  APB strobes
PPROT  output  3  APB protection
PSELx  output  1  APB select
PENABLE  output  1  APB enable
PREADY  input  1  slave ready
PRDATA  input  DATA_WIDTH  slave read data
PSLVERR  input  1  slave error

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - State goes to IDLE.
  - All outputs go to 0, including req_ready, rsp_valid, PSELx and PENABLE.
  - Wait counter clears.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - req_ready=1 only in IDLE and only when not in reset.
  - On req_valid&&req_ready: latch the command into PADDR/PWRITE/PWDATA/PSTRB/PPROT and go to SETUP.
  - Next cycle: PSELx=1, PENABLE=0.
- PSTRB is forced to 0 for reads. PWDATA carries the latched req_wdata in both directions.
- SETUP: lasts exactly 1 cycle, then ACCESS with PSELx=1, PENABLE=1. Wait counter is cleared on entry to ACCESS.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT are stable from SETUP through the end of ACCESS.
- ACCESS with PREADY=1:
  - Capture PRDATA for reads (0 for writes) into rsp_rdata and PSLVERR into rsp_slverr; rsp_timeout=0.
  - Next cycle: PSELx=0, PENABLE=0, rsp_valid=1, state RESP.
  - PSLVERR is sampled only in this cycle.
- Timeout:
  - Condition: TIMEOUT_CYCLES!=0, wait counter == TIMEOUT_CYCLES and PREADY=0.
  - Next cycle: PSELx=0, PENABLE=0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, state RESP.
  - If PREADY=1 in that same cycle, the normal completion wins.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle and state goes to IDLE.
  - req_ready does not rise until IDLE.
- Minimum transfer cost:
  - Zero-wait transfer with rsp_ready tied high: accept edge, then SETUP, ACCESS, RESP.
  - Next accept is possible 4 cycles after the previous one.
- After a transfer, PADDR/PWRITE/PWDATA/PSTRB/PPROT hold their last values. PSELx and PENABLE are 0 outside SETUP/ACCESS.
- Reset mid-transfer (any state): PSELx/PENABLE drop at the reset edge, the in-flight response is discarded and no rsp_valid is generated.
- Wait counter saturates at its maximum. It never wraps, including when TIMEOUT_CYCLES=0.

Test Plan:
- Zero-wait write: addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY=1 -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid=1, rsp_slverr=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x20, PRDATA=0xA5A5_5A5A asserted with PREADY on the 4th ACCESS cycle -> PENABLE high 4 cycles, rsp_rdata=0xA5A55A5A, PSTRB=0 throughout.
- Slave error: write to 0x30, PREADY=1, PSLVERR=1 -> rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0 -> PSELx/PENABLE drop after 17 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- Response back-pressure: rsp_ready=0 for 5 cycles after completion -> rsp_* stable, req_ready=0, no new SETUP; rsp_ready=1 -> IDLE next cycle and req_ready=1.
- Reset in ACCESS: PRESET=1 during a 2nd wait cycle -> PSELx=PENABLE=rsp_valid=req_ready=0 after the edge, no response emitted; after release, a new zero-wait read completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Signal bundle between a command/response client, the APB master bridge and its APB slave.
// The master modport is the bridge's view; the slave modport is the client/slave side.
interface apb_master_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_strb;
    logic [2:0]                req_prot;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_slverr;
    logic                      rsp_timeout;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic                      PWRITE;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic                      PSELx;
    logic                      PENABLE;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSELx, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSELx, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3/APB4 master bridge with buffered response and PREADY timeout.
// Every output is a register; the output process only computes next-state values.
module apb_master_bridge #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus_io
);
    localparam int unsigned           StrbWidth  = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0]  TimeoutVal = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CntMax     = '1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [StrbWidth-1:0]    pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;

    logic accept;
    logic timeout_hit;

    assign accept      = bus_io.req_valid & req_ready_q;
    // A PREADY seen in the deadline cycle still completes normally.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutVal) && !bus_io.PREADY;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (bus_io.PREADY || timeout_hit) state_d = StResp;
            StResp:   if (bus_io.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        req_ready_d   = (state_d == StIdle);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    paddr_d  = bus_io.req_addr;
                    pwrite_d = bus_io.req_write;
                    pwdata_d = bus_io.req_wdata;
                    pstrb_d  = bus_io.req_write ? bus_io.req_strb : '0;
                    pprot_d  = bus_io.req_prot;
                    psel_d   = 1'b1;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                if (bus_io.PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus_io.PRDATA;
                    rsp_slverr_d  = bus_io.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (bus_io.rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus_io.req_ready   = req_ready_q;
    assign bus_io.rsp_valid   = rsp_valid_q;
    assign bus_io.rsp_rdata   = rsp_rdata_q;
    assign bus_io.rsp_slverr  = rsp_slverr_q;
    assign bus_io.rsp_timeout = rsp_timeout_q;
    assign bus_io.PADDR       = paddr_q;
    assign bus_io.PWRITE      = pwrite_q;
    assign bus_io.PWDATA      = pwdata_q;
    assign bus_io.PSTRB       = pstrb_q;
    assign bus_io.PPROT       = pprot_q;
    assign bus_io.PSELx       = psel_q;
    assign bus_io.PENABLE     = penable_q;
endmodule
